sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
Bridges the 32-bit pipeline MEM stage to the external 16-bit asynchronous-read, synchronous-write SRAM. Each 32-bit load/store becomes two 16-bit SRAM accesses (low half, then high half) plus a fixed wait period. The block stalls the pipeline through a ready signal until the transaction completes. It drives the SRAM address, active-low write enable and bidirectional data bus directly.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0.
WAIT_CYCLES, 2, idle cycles inserted after the high-half access (range 0..15).

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  store request from MEM stage
rd_en  in  1  load request from MEM stage
address  in  32  byte address of access
write_data  in  32  store data
read_data  out  32  load data, registered
ready  out  1  high = no stall; low = freeze pipeline
SRAM_ADDR  out  18  SRAM word address
SRAM_WE_N  out  1  SRAM write enable, active low
SRAM_DQ  inout  16  SRAM data bus

Behaviour:
- Reset: state=IDLE, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z. Reset mid-transaction aborts it immediately; a half-written word stays half-written.
- Address map: offset = address - BASE_ADDR (32-bit, wrapping subtraction). SRAM_ADDR low half = {offset[18:2],1'b0}; high half = {offset[18:2],1'b1}. address[1:0] is ignored.
- States: IDLE, LOW, HIGH, WAIT, DONE.
- IDLE: if wr_en|rd_en, latch cmd (write if wr_en, else read; write wins when both are high), address and write_data, then go to LOW. Otherwise stay in IDLE.
- LOW: drive the low-half address. Write: SRAM_WE_N=0 and SRAM_DQ=wdata[15:0]. Read: SRAM_WE_N=1 and capture SRAM_DQ into read_data[15:0] at the closing edge. Go to HIGH.
- HIGH: same as LOW for the high-half address and bits [31:16]. Then go to WAIT, or to DONE if WAIT_CYCLES=0.
- WAIT: SRAM_WE_N=1. A 4-bit counter, loaded to 0 on entry, counts up; leave for DONE when count = WAIT_CYCLES-1.
- DONE: one cycle, then IDLE.
- Outputs in IDLE, WAIT and DONE: SRAM_WE_N=1 and SRAM_DQ=Z. SRAM_DQ is driven only while SRAM_WE_N=0. SRAM_WE_N and SRAM_ADDR are decoded from the state register only, never from the request inputs.
- ready = ~(wr_en|rd_en) | (state==DONE), combinational.
- Latency: request first seen in IDLE at cycle 0 → LOW cycle 1, HIGH cycle 2, WAIT cycles 3..2+W, DONE cycle 3+W (cycle 5 for W=2). ready is high only in DONE.
- read_data updates only on reads and holds its value otherwise. It is valid in DONE and afterwards.
- Request inputs that change or drop after the IDLE latch are ignored until the block returns to IDLE. A request still asserted in the cycle after DONE starts a new transaction.

Optional Feature:
Macro SRAM_ADDR_CHECK_EN.
- Defined: adds output port addr_err (1 bit, reset 0).
  - A request with address < BASE_ADDR or address[1:0]!=0 skips LOW/HIGH/WAIT and goes IDLE→DONE.
  - No SRAM write occurs and read_data is unchanged.
  - addr_err=1 during that DONE cycle only.
- Not defined: no addr_err port and no checks; every request follows the normal path.

Test Plan:
- No request, rd_en=wr_en=0 for 10 cycles → ready=1, SRAM_WE_N=1, SRAM_DQ=Z throughout.
- Store 32'hDEADBEEF to address 1024 with W=2 → SRAM word 0 = 16'hBEEF and word 1 = 16'hDEAD; SRAM_WE_N low in cycles 1 and 2 only; ready=1 only in cycle 5.
- Load from address 1024 after the store → read_data = 32'hDEADBEEF in DONE; store to 1028 followed by load from 1028 → SRAM_ADDR 2 then 3, correct data.
- wr_en=rd_en=1 with address 1032 and data 32'h12345678 → treated as store; read_data unchanged; SRAM words 4 and 5 = 16'h5678 and 16'h1234.
- Assert rst during HIGH of a store → next cycle IDLE, SRAM_WE_N=1, read_data=0, word 1 not written; a subsequent load completes normally.
- With SRAM_ADDR_CHECK_EN: load from 1026 or from 512 → DONE in cycle 1 with addr_err=1, no SRAM access, read_data unchanged.

Source files
------------

// File: rtl/sram_controller.sv
// 32-bit MEM-stage bridge to a 16-bit async-read / sync-write SRAM: low half, high half, then a wait period.
// Optional macro SRAM_ADDR_CHECK_EN adds addr_err and short-circuits out-of-range or misaligned requests.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
`ifdef SRAM_ADDR_CHECK_EN
    output logic        addr_err,
`endif
    inout  wire  [15:0] SRAM_DQ
);

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    state_t      next_state;
    logic        cmd_write;
    logic [16:0] word_idx;
    logic [31:0] wdata;
    logic [3:0]  wait_cnt;
    logic [15:0] dq_out;
    logic        req;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign req    = wr_en | rd_en;
    assign offset = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    logic bad_addr;
    logic err_q;
    assign bad_addr = (address < 32'(BASE_ADDR)) || (address[1:0] != 2'b00);
    assign addr_err = (state == S_DONE) && err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
`ifdef SRAM_ADDR_CHECK_EN
                    next_state = bad_addr ? S_DONE : S_LOW;
`else
                    next_state = S_LOW;
`endif
                end
            end
            S_LOW:   next_state = S_HIGH;
            S_HIGH:  next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT:  next_state = (wait_cnt == WAIT_LAST) ? S_DONE : S_WAIT;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // SRAM strobes come from the state register alone so request glitches never reach the pins
    always_comb begin
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_out    = '0;
        case (state)
            S_LOW: begin
                SRAM_ADDR = {word_idx, 1'b0};
                SRAM_WE_N = ~cmd_write;
                dq_out    = wdata[15:0];
            end
            S_HIGH: begin
                SRAM_ADDR = {word_idx, 1'b1};
                SRAM_WE_N = ~cmd_write;
                dq_out    = wdata[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ = SRAM_WE_N ? 16'bz : dq_out;
    assign ready   = ~req | (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write <= 1'b0;
            wait_cnt  <= '0;
            read_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && req) begin
                cmd_write <= wr_en;
`ifdef SRAM_ADDR_CHECK_EN
                err_q     <= bad_addr;
`endif
            end
            if (state == S_HIGH) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state == S_LOW && !cmd_write) begin
                read_data[15:0] <= SRAM_DQ;
            end
            if (state == S_HIGH && !cmd_write) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // Address and store data are datapath only; they are don't-care until the next latch
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            word_idx <= offset[18:2];
            wdata    <= write_data;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized directed bench for sram_controller against a word-level memory model and a cycle-count latency rule.
module tb_sram_controller;
    localparam int BASE = 1024;
    localparam int W    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    wire  [15:0] SRAM_DQ;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:1023];
    logic        park;
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd;
    int          keys[$];

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err(addr_err),
`endif
        .SRAM_DQ(SRAM_DQ)
    );

    // External SRAM: drives the bus whenever it is not being written
    assign SRAM_DQ = !SRAM_WE_N ? 16'bz : (park ? 16'hA5C3 : mem[SRAM_ADDR[9:0]]);
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; request held until ready, address/data scrambled after the latch
    task automatic run_txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        int          k;
        int          cyc;
        bit          seen;
        off  = a - 32'(BASE);
        k    = int'(off >> 2);
        seen = 0;
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1 check("ready_cycle0", {31'b0, ready}, 32'd0);
        for (cyc = 1; cyc <= 30 && !seen; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                address = $urandom; write_data = $urandom;
            end
            check("we_n", {31'b0, SRAM_WE_N}, {31'b0, !(w && (cyc == 1 || cyc == 2))});
            if (cyc == 1 || cyc == 2) begin
                check("sram_addr", {14'b0, SRAM_ADDR}, 32'(2 * k + cyc - 1));
                if (w) check("dq_drive", {16'b0, SRAM_DQ}, {16'b0, (cyc == 1) ? d[15:0] : d[31:16]});
            end
            check("ready_latency", {31'b0, ready}, {31'b0, cyc == 3 + W});
            if (ready) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        if (w) ref_mem[k] = d;
        else   ref_rd = ref_mem[k];
        check("read_data", read_data, ref_rd);
        if (w) begin
            check("mem_lo", {16'b0, mem[2 * k]},     {16'b0, d[15:0]});
            check("mem_hi", {16'b0, mem[2 * k + 1]}, {16'b0, d[31:16]});
            keys.push_back(k);
        end
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        logic [31:0] old_word;
        logic [31:0] d;
        int          k;
        rst = 1'b1; wr_en = 0; rd_en = 0; address = 0; write_data = 0; park = 1'b1; ref_rd = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("rst_addr", {14'b0, SRAM_ADDR}, 32'd0);
        check("rst_ready", {31'b0, ready}, 32'd1);
        rst = 1'b0;

        // Idle: the bus must carry only the SRAM's parked value
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, ready}, 32'd1);
            check("idle_we_n", {31'b0, SRAM_WE_N}, 32'd1);
            check("idle_dq", {16'b0, SRAM_DQ}, 32'h0000A5C3);
        end
        park = 1'b0;

        run_txn(1, 0, 32'd1024, 32'hDEADBEEF);
        run_txn(0, 1, 32'd1024, 32'h0);
        check("load_deadbeef", read_data, 32'hDEADBEEF);
        d = $urandom;
        run_txn(1, 0, 32'd1028, d);
        run_txn(0, 1, 32'd1028, 32'h0);
        check("load_1028", read_data, d);
        run_txn(1, 1, 32'd1032, 32'h12345678);
        check("both_mem4", {16'b0, mem[4]}, 32'h5678);
        check("both_mem5", {16'b0, mem[5]}, 32'h1234);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0 || keys.size() == 0) begin
                k = $urandom_range(0, 199);
                run_txn(1, 0, 32'(BASE + 4 * k) | 32'($urandom_range(0, 3) & 0), $urandom);
            end else begin
                k = keys[$urandom_range(0, keys.size() - 1)];
                run_txn(0, 1, 32'(BASE + 4 * k), $urandom);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the high half of a store over word 0
        run_txn(0, 1, 32'd1028, 32'h0);
        old_word = ref_mem[0];
        d = ~old_word;
        @(negedge clk);
        wr_en = 1; address = 32'd1024; write_data = d;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("pre_rst_high_addr", {14'b0, SRAM_ADDR}, 32'd1);
        rst = 1'b1; wr_en = 0;
        #1;
        check("midrst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("midrst_read_data", read_data, 32'd0);
        check("midrst_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ref_rd = 0;
        ref_mem[0] = {old_word[31:16], d[15:0]};
        check("midrst_mem_hi", {16'b0, mem[1]}, {16'b0, old_word[31:16]});
        run_txn(0, 1, 32'd1024, 32'h0);
        check("post_rst_load", read_data, {old_word[31:16], d[15:0]});

`ifdef SRAM_ADDR_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            logic [31:0] bad;
            logic [15:0] m0;
            logic [15:0] m1;
            bad = (i == 0) ? 32'd1026 : (i == 1) ? 32'd512 : 32'd1025;
            m0 = mem[0]; m1 = mem[1];
            @(negedge clk);
            rd_en = (i != 2); wr_en = (i == 2); address = bad; write_data = 32'hFFFF0000;
            #1 check("err_cycle0", {31'b0, addr_err}, 32'd0);
            @(posedge clk); @(negedge clk);
            check("err_ready", {31'b0, ready}, 32'd1);
            check("err_flag", {31'b0, addr_err}, 32'd1);
            check("err_we_n", {31'b0, SRAM_WE_N}, 32'd1);
            check("err_read_data", read_data, ref_rd);
            rd_en = 0; wr_en = 0;
            @(negedge clk);
            check("err_clear", {31'b0, addr_err}, 32'd0);
            check("err_mem0", {16'b0, mem[0]}, {16'b0, m0});
            check("err_mem1", {16'b0, mem[1]}, {16'b0, m1});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
